branch_resolve: RTL and testbench



---
 rtl/branch_resolve_if.sv | 58 +++++
 rtl/branch_resolve.sv | 148 ++++++++++++++
 tb/tb_branch_resolve.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Shared compare-opcode type plus the instruction / redirect / result bundle of branch_resolve.
// Handshake: a beat moves on a clock edge where valid && ready; res_valid is a pulse with no ready.
package branch_resolve_pkg;
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_t;
endpackage

interface branch_resolve_if #(
  parameter int XLEN = 32
);
  import branch_resolve_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  cmp_op_t         in_cmp_op;
  logic            in_is_jal;
  logic            in_is_jalr;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;
  logic            res_misalign;
  logic [XLEN-1:0] res_link;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_cmp_op,
           in_is_jal, in_is_jalr, in_pred_taken, in_pred_target,
    input  in_ready,
    input  redirect_valid, redirect_pc,
    output redirect_ready,
    input  res_valid, res_taken, res_mispredict, res_misalign, res_link
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_cmp_op,
           in_is_jal, in_is_jalr, in_pred_taken, in_pred_target,
    output in_ready,
    output redirect_valid, redirect_pc,
    input  redirect_ready,
    output res_valid, res_taken, res_mispredict, res_misalign, res_link
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: evaluates one control transfer per transaction, redirects fetch on mispredict.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolve_if.slave   bus,
  output logic [XLEN-1:0]   cmp_a,
  output logic [XLEN-1:0]   cmp_b,
  output cmp_op_t           cmp_op,
  input  logic              cmp_result,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_mispredict,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVAL     = 2'd1,
    S_REDIRECT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, pred_target_q;
  cmp_op_t         op_q;
  logic            is_jal_q, is_jalr_q, pred_taken_q;

  logic            res_taken_q, res_mispredict_q, res_misalign_q;
  logic [XLEN-1:0] res_link_q, redirect_pc_q;

  logic            op_legal;
  logic            taken_c, misalign_c, mispredict_c;
  logic [XLEN-1:0] sum_c, target_c, link_c;

  // Outcome is derived from the registered instruction and the compare unit's answer.
  always_comb begin
    op_legal     = (op_q <= CMP_GEU);
    taken_c      = (is_jal_q | is_jalr_q) ? 1'b1 : (op_legal & cmp_result);
    sum_c        = is_jalr_q ? (rs1_q + imm_q) : (pc_q + imm_q);
    target_c     = is_jalr_q ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
    link_c       = pc_q + XLEN'(4);
    misalign_c   = taken_c & target_c[1];
    mispredict_c = ~misalign_c &
                   ((taken_c != pred_taken_q) | (taken_c & (target_c != pred_target_q)));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.in_valid) state_d = S_EVAL;
      S_EVAL:     state_d = mispredict_c ? S_REDIRECT : S_RESP;
      S_REDIRECT: if (bus.redirect_ready) state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      imm_q            <= '0;
      pred_target_q    <= '0;
      op_q             <= CMP_EQ;
      is_jal_q         <= 1'b0;
      is_jalr_q        <= 1'b0;
      pred_taken_q     <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_misalign_q   <= 1'b0;
      res_link_q       <= '0;
      redirect_pc_q    <= '0;
    end else begin
      if (state_q == S_IDLE && bus.in_valid) begin
        pc_q          <= bus.in_pc;
        rs1_q         <= bus.in_rs1;
        rs2_q         <= bus.in_rs2;
        imm_q         <= bus.in_imm;
        pred_target_q <= bus.in_pred_target;
        op_q          <= bus.in_cmp_op;
        is_jal_q      <= bus.in_is_jal;
        is_jalr_q     <= bus.in_is_jalr;
        pred_taken_q  <= bus.in_pred_taken;
      end
      // Result fields keep the previous outcome until the next evaluation overwrites them.
      if (state_q == S_EVAL) begin
        res_taken_q      <= taken_c;
        res_mispredict_q <= mispredict_c;
        res_misalign_q   <= misalign_c;
        res_link_q       <= link_c;
        redirect_pc_q    <= taken_c ? target_c : link_c;
      end
    end
  end

  // Handshake strobes decode straight from state so reset removes them asynchronously.
  assign bus.in_ready       = (state_q == S_IDLE);
  assign bus.redirect_valid = (state_q == S_REDIRECT);
  assign bus.res_valid      = (state_q == S_RESP);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.res_misalign   = res_misalign_q;
  assign bus.res_link       = res_link_q;

  assign cmp_a     = rs1_q;
  assign cmp_b     = rs2_q;
  assign cmp_op    = op_q;
  assign state_dbg = state_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] cnt_br_q, cnt_tk_q, cnt_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_br_q <= '0;
      cnt_tk_q <= '0;
      cnt_mp_q <= '0;
    end else if (state_q == S_RESP) begin
      cnt_br_q <= cnt_br_q + STAT_W'(1);
      if (res_taken_q)      cnt_tk_q <= cnt_tk_q + STAT_W'(1);
      if (res_mispredict_q) cnt_mp_q <= cnt_mp_q + STAT_W'(1);
    end
  end

  assign stat_branches   = cnt_br_q;
  assign stat_taken      = cnt_tk_q;
  assign stat_mispredict = cnt_mp_q;
`else
  assign stat_branches   = '0;
  assign stat_taken      = '0;
  assign stat_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed and randomized bench for branch_resolve with a spec-level outcome model and a link scoreboard.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) bus ();

  logic [31:0] cmp_a, cmp_b;
  cmp_op_t     cmp_op;
  logic        cmp_result;
  logic [31:0] stat_branches, stat_taken, stat_mispredict;
  logic [1:0]  state_dbg;

  branch_resolve #(.XLEN(32), .STAT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .cmp_a           (cmp_a),
    .cmp_b           (cmp_b),
    .cmp_op          (cmp_op),
    .cmp_result      (cmp_result),
    .stat_branches   (stat_branches),
    .stat_taken      (stat_taken),
    .stat_mispredict (stat_mispredict),
    .state_dbg       (state_dbg)
  );

  // Stand-in for the external compare unit.
  always_comb begin
    cmp_result = 1'b0;
    case (cmp_op)
      CMP_EQ:  cmp_result = (cmp_a == cmp_b);
      CMP_NE:  cmp_result = (cmp_a != cmp_b);
      CMP_LT:  cmp_result = ($signed(cmp_a) <  $signed(cmp_b));
      CMP_GE:  cmp_result = ($signed(cmp_a) >= $signed(cmp_b));
      CMP_LTU: cmp_result = (cmp_a <  cmp_b);
      CMP_GEU: cmp_result = (cmp_a >= cmp_b);
      default: cmp_result = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int m_br = 0, m_tk = 0, m_mp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int v);
`ifdef BRANCH_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_stat_br"}, stat_branches,   exp_stat(m_br));
    check({tag, "_stat_tk"}, stat_taken,      exp_stat(m_tk));
    check({tag, "_stat_mp"}, stat_mispredict, exp_stat(m_mp));
  endtask

  // Reference outcome straight from the architectural rules.
  function automatic void model(
    input  logic [31:0] pc, rs1, rs2, imm,
    input  logic [2:0]  op,
    input  logic        jal, jalr, pt,
    input  logic [31:0] ptgt,
    output logic        taken, mis, mal,
    output logic [31:0] tgt, link, rpc
  );
    logic c;
    case (op)
      3'd0:    c = (rs1 == rs2);
      3'd1:    c = (rs1 != rs2);
      3'd2:    c = ($signed(rs1) <  $signed(rs2));
      3'd3:    c = ($signed(rs1) >= $signed(rs2));
      3'd4:    c = (rs1 <  rs2);
      3'd5:    c = (rs1 >= rs2);
      default: c = 1'b0;
    endcase
    taken = (jal || jalr) ? 1'b1 : c;
    tgt   = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    link  = pc + 32'd4;
    mal   = taken && tgt[1];
    mis   = !mal && ((taken != pt) || (taken && (tgt != ptgt)));
    rpc   = taken ? tgt : link;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_in(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] op,
                          input logic jal, jalr, pt, input logic [31:0] ptgt);
    bus.in_valid       = 1'b1;
    bus.in_pc          = pc;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_imm         = imm;
    bus.in_cmp_op      = cmp_op_t'(op);
    bus.in_is_jal      = jal;
    bus.in_is_jalr     = jalr;
    bus.in_pred_taken  = pt;
    bus.in_pred_target = ptgt;
  endtask

  task automatic scramble_in();
    bus.in_valid  = 1'b0;
    bus.in_pc     = $urandom;
    bus.in_rs1    = $urandom;
    bus.in_rs2    = $urandom;
    bus.in_imm    = $urandom;
    bus.in_cmp_op = cmp_op_t'(3'($urandom_range(0, 7)));
  endtask

  task automatic run_txn(input string tag, input logic [31:0] pc, rs1, rs2, imm,
                         input logic [2:0] op, input logic jal, jalr, pt,
                         input logic [31:0] ptgt, input int stall);
    logic e_taken, e_mis, e_mal;
    logic [31:0] e_tgt, e_link, e_rpc;
    model(pc, rs1, rs2, imm, op, jal, jalr, pt, ptgt, e_taken, e_mis, e_mal, e_tgt, e_link, e_rpc);
    exp_q.push_back(e_link);

    @(negedge clk);
    check({tag, "_in_ready_idle"}, {31'b0, bus.in_ready}, 32'd1);
    drive_in(pc, rs1, rs2, imm, op, jal, jalr, pt, ptgt);
    bus.redirect_ready = 1'($urandom_range(0, 1));

    @(negedge clk);  // cycle 1: EVAL
    scramble_in();
    check({tag, "_cmp_a"},  cmp_a, rs1);
    check({tag, "_cmp_b"},  cmp_b, rs2);
    check({tag, "_cmp_op"}, {29'b0, cmp_op}, {29'b0, op});
    check({tag, "_eval_busy"}, {30'b0, bus.in_ready, bus.res_valid}, 32'd0);

    @(negedge clk);  // cycle 2
    bus.redirect_ready = 1'b0;
    if (e_mis) begin
      for (int s = 0; s < stall; s++) begin
        check({tag, "_redir_valid_stall"}, {31'b0, bus.redirect_valid}, 32'd1);
        check({tag, "_redir_pc_stall"},    bus.redirect_pc, e_rpc);
        check({tag, "_res_valid_stall"},   {31'b0, bus.res_valid}, 32'd0);
        @(negedge clk);
      end
      check({tag, "_redir_valid"}, {31'b0, bus.redirect_valid}, 32'd1);
      check({tag, "_redir_pc"},    bus.redirect_pc, e_rpc);
      bus.redirect_ready = 1'b1;
      @(negedge clk);
      bus.redirect_ready = 1'b0;
    end else begin
      check({tag, "_no_redirect"}, {31'b0, bus.redirect_valid}, 32'd0);
    end

    check({tag, "_res_valid"},  {31'b0, bus.res_valid}, 32'd1);
    check({tag, "_res_flags"},
          {29'b0, bus.res_taken, bus.res_mispredict, bus.res_misalign},
          {29'b0, e_taken, e_mis, e_mal});
    check({tag, "_res_link"}, bus.res_link, exp_q.pop_front());
    m_br++;
    if (e_taken) m_tk++;
    if (e_mis)   m_mp++;

    @(negedge clk);
    check({tag, "_res_pulse_end"}, {31'b0, bus.res_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'b0, bus.in_ready}, 32'd1);
    check_stats(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic e_taken, e_mis, e_mal;
    logic [31:0] e_tgt, e_link, e_rpc;
    logic [31:0] r_pc, r_rs1, r_rs2, r_imm, r_ptgt;
    logic [2:0]  r_op;
    logic        r_jal, r_jalr, r_pt;
    int          k;

    rst_n = 1'b0;
    scramble_in();
    bus.in_is_jal      = 1'b0;
    bus.in_is_jalr     = 1'b0;
    bus.in_pred_taken  = 1'b0;
    bus.in_pred_target = '0;
    bus.redirect_ready = 1'b0;
    #2;
    check("rst_in_ready",   {31'b0, bus.in_ready}, 32'd1);
    check("rst_strobes",    {30'b0, bus.redirect_valid, bus.res_valid}, 32'd0);
    check("rst_res_flags",  {29'b0, bus.res_taken, bus.res_mispredict, bus.res_misalign}, 32'd0);
    check("rst_res_link",   bus.res_link, 32'd0);
    check("rst_redir_pc",   bus.redirect_pc, 32'd0);
    check("rst_cmp_ab",     cmp_a | cmp_b, 32'd0);
    check("rst_cmp_op",     {29'b0, cmp_op}, 32'd0);
    check_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_txn("blt",      32'h100, 32'hFFFF_FFFF, 32'h1, 32'h40, 3'd2, 0, 0, 1, 32'h140, 0);
    run_txn("bltu",     32'h100, 32'hFFFF_FFFF, 32'h1, 32'h40, 3'd4, 0, 0, 1, 32'h140, 3);
    check("bltu_redir_pc_held", bus.redirect_pc, 32'h104);
    run_txn("jalr_mal", 32'h500, 32'h1001, 32'h0, 32'h2, 3'd0, 0, 1, 0, 32'h0, 0);
    run_txn("jalr_ok",  32'h500, 32'h1001, 32'h0, 32'h3, 3'd0, 0, 1, 0, 32'h0, 1);
    check("jalr_ok_redir_pc", bus.redirect_pc, 32'h1004);
    run_txn("beq_wrap", 32'hFFFF_FFFC, 32'h55, 32'h55, 32'h8, 3'd0, 0, 0, 1, 32'h4, 0);
    check("beq_wrap_link", bus.res_link, 32'h0);
    run_txn("illegal6", 32'h300, 32'h7, 32'h7, 32'h10, 3'd6, 0, 0, 0, 32'h0, 0);
    run_txn("illegal7", 32'h300, 32'h7, 32'h8, 32'h10, 3'd7, 0, 0, 1, 32'h310, 2);
    run_txn("jal",      32'h400, 32'h0, 32'h0, 32'hFFFF_FF00, 3'd7, 1, 0, 1, 32'h300, 0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      r_pc  = $urandom;
      r_rs1 = $urandom;
      r_rs2 = ($urandom_range(0, 3) == 0) ? r_rs1 : 32'($urandom);
      r_imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      r_op  = 3'($urandom_range(0, 7));
      k     = $urandom_range(0, 3);
      r_jal  = (k == 1);
      r_jalr = (k == 2);
      model(r_pc, r_rs1, r_rs2, r_imm, r_op, r_jal, r_jalr, 1'b0, 32'h0,
            e_taken, e_mis, e_mal, e_tgt, e_link, e_rpc);
      r_pt   = ($urandom_range(0, 2) != 0) ? e_taken : 1'($urandom_range(0, 1));
      r_ptgt = ($urandom_range(0, 2) != 0) ? e_tgt : 32'($urandom);
      run_txn("rand", r_pc, r_rs1, r_rs2, r_imm, r_op, r_jal, r_jalr, r_pt, r_ptgt,
              $urandom_range(0, 3));
    end

    // Reset while a redirect is pending
    @(negedge clk);
    drive_in(32'h100, 32'hFFFF_FFFF, 32'h1, 32'h40, 3'd4, 0, 0, 1, 32'h140);
    @(negedge clk);
    scramble_in();
    @(negedge clk);
    check("rstmid_redir_before", {31'b0, bus.redirect_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    m_br = 0; m_tk = 0; m_mp = 0;
    check("rstmid_redir_drop", {31'b0, bus.redirect_valid}, 32'd0);
    check("rstmid_res_valid",  {31'b0, bus.res_valid}, 32'd0);
    check_stats("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_stats("rstmid_after");

    // Ten branches: six taken, three mispredicted
    for (int i = 0; i < 10; i++) begin
      if (i < 6)
        run_txn("stat_beq", 32'h200, 32'h9, 32'h9, 32'h10, 3'd0, 0, 0, (i < 4), 32'h210, 0);
      else
        run_txn("stat_bne", 32'h200, 32'h9, 32'h9, 32'h10, 3'd1, 0, 0, (i == 9), 32'h210, 0);
    end
    check("final_stat_br", stat_branches,   exp_stat(10));
    check("final_stat_tk", stat_taken,      exp_stat(6));
    check("final_stat_mp", stat_mispredict, exp_stat(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
